// File: rtl/dma_arbiter.sv
// dma_arbiter
// Shares one downstream DMA memory port among NCH requesters. Channels are
// granted round-robin. A grant is held until the owner drops its request or
// MAX_BURST accesses have been accepted. Every accepted access stores the
// owner's channel number in a tag FIFO, so that the in-order downstream
// completions can be routed back to the channel that issued them.
//
// Ports
//   clk, rst         system clock; synchronous active-high reset
//   c_req/c_rnw      per-channel request and direction (1 = read)
//   c_addr/c_wd      per-channel address / write data, channel i at [i*W +: W]
//   c_ack/c_done     per-channel accept / completion strobes
//   c_rd             read data, valid while any c_done bit is set
//   req/rnw/addr/wd  downstream request and the owner's access fields
//   ack/done/rd      downstream accept, in-order completion, read data
//   err              sticky flag: a done arrived with no access outstanding
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no grant; pick the next requester after r_last, round-robin
// GRANT | r_owner drives the downstream port until release or burst limit

module dma_arbiter #(
    parameter int NCH       = 4,
    parameter int AW        = 21,
    parameter int DW        = 8,
    parameter int MAX_BURST = 16,
    parameter int TAG_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    c_req,
    input  logic [NCH-1:0]    c_rnw,
    input  logic [NCH*AW-1:0] c_addr,
    input  logic [NCH*DW-1:0] c_wd,
    output logic [NCH-1:0]    c_ack,
    output logic [NCH-1:0]    c_done,
    output logic [DW-1:0]     c_rd,
    output logic              req,
    output logic              rnw,
    output logic [AW-1:0]     addr,
    output logic [DW-1:0]     wd,
    input  logic              ack,
    input  logic              done,
    input  logic [DW-1:0]     rd,
    output logic              err
);

    localparam int TW = $clog2(NCH);
    localparam int PW = $clog2(TAG_DEPTH);
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [TW-1:0]  r_owner;
    logic [TW-1:0]  r_last;
    logic [TW-1:0]  w_winner;
    logic [7:0]     r_bcnt;
    logic [TW-1:0]  r_tag [TAG_DEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [PW:0]    r_count;
    logic           r_err;
    logic           w_own_req;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;

    // Scan from r_last+NCH down to r_last+1 so the last hit is the first
    // requester after r_last in round-robin order.
    always_comb begin
        w_winner = '0;
        for (int k = NCH; k >= 1; k--) begin
            int idx;
            idx = (int'(r_last) + k) % NCH;
            if (c_req[idx]) begin
                w_winner = TW'(idx);
            end
        end
    end

    assign w_own_req = c_req[r_owner];
    assign w_full    = (r_count == (PW+1)'(TAG_DEPTH));
    assign w_empty   = (r_count == '0);
    // Full masks req even when a pop happens this cycle; this keeps the
    // mask free of any path from the downstream done.
    assign req       = (r_state == S_GRANT) && w_own_req && !w_full;
    assign w_push    = (r_state == S_GRANT) && ack;
    assign w_pop     = done && !w_empty;

    assign rnw  = c_rnw[r_owner];
    assign addr = c_addr[int'(r_owner)*AW +: AW];
    assign wd   = c_wd[int'(r_owner)*DW +: DW];
    assign c_rd = rd;
    assign err  = r_err;

    always_comb begin
        c_ack            = '0;
        c_ack[r_owner]   = w_push;
        c_done           = '0;
        c_done[r_tag[r_rptr]] = w_pop;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (|c_req) begin
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!w_own_req || (w_push && r_bcnt == BURST_LAST)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_last  <= TW'(NCH - 1);
            r_bcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && |c_req) begin
                r_owner <= w_winner;
                r_bcnt  <= '0;
            end
            if (r_state == S_GRANT) begin
                if (w_push) begin
                    r_bcnt <= r_bcnt + 8'd1;
                end
                if (w_state_nxt == S_IDLE) begin
                    r_last <= r_owner;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag[r_wptr] <= r_owner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (done && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dma_arbiter.sv
// Testbench for dma_arbiter: directed steps with a downstream controller
// model and a completion scoreboard filled from the channels' own view of
// each accepted access.

module tb_dma_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 21;
    localparam int DW  = 8;
    localparam int MB  = 4;
    localparam int TD  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    c_req;
    logic [NCH-1:0]    c_rnw;
    logic [NCH*AW-1:0] c_addr;
    logic [NCH*DW-1:0] c_wd;
    logic [NCH-1:0]    c_ack;
    logic [NCH-1:0]    c_done;
    logic [DW-1:0]     c_rd;
    logic              req;
    logic              rnw;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wd;
    logic              ack;
    logic              done;
    logic [DW-1:0]     rd;
    logic              err;
    logic              ack_en;
    logic              inj;

    dma_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .MAX_BURST(MB), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst(rst), .c_req(c_req), .c_rnw(c_rnw), .c_addr(c_addr),
        .c_wd(c_wd), .c_ack(c_ack), .c_done(c_done), .c_rd(c_rd), .req(req),
        .rnw(rnw), .addr(addr), .wd(wd), .ack(ack), .done(done), .rd(rd), .err(err)
    );

    always #5 clk = ~clk;

    assign ack = req & ack_en;

    typedef struct { int due; logic [DW-1:0] data; } dn_t;
    typedef struct { int ch; logic rnw; logic [DW-1:0] rd; } exp_t;

    dn_t  dq[$];
    exp_t sb[$];
    int   ack_log[$];
    int   ack_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   lat = 2;
    int   rem[NCH];
    logic [AW-1:0] ca[NCH];
    logic [DW-1:0] cw[NCH];
    logic          crnw[NCH];
    int   cnt_ack[NCH];
    int   cnt_done[NCH];
    int   rr[3] = '{0, 1, 3};
    int   seq5[5] = '{0, 0, 1, 1, 1};

    function automatic logic [DW-1:0] rdfun(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ch();
        for (int i = 0; i < NCH; i++) begin
            c_req[i] = (rem[i] > 0);
            c_rnw[i] = crnw[i];
            c_addr[i*AW +: AW] = ca[i];
            c_wd[i*DW +: DW]   = cw[i];
        end
    endtask

    task automatic set_ch(input int i, input int n, input logic [AW-1:0] base, input logic r);
        rem[i]  = n;
        ca[i]   = base;
        cw[i]   = base[7:0] ^ 8'h3C;
        crnw[i] = r;
        drive_ch();
    endtask

    task automatic clr_log();
        ack_log.delete();
        ack_cyc.delete();
        for (int i = 0; i < NCH; i++) begin
            cnt_ack[i]  = 0;
            cnt_done[i] = 0;
        end
    endtask

    // One clock: sample and score at the falling edge, then drive channel
    // and downstream inputs 1 time unit after the rising edge.
    task automatic step();
        logic [NCH-1:0] acks;
        exp_t e;
        @(negedge clk);
        acks = c_ack;
        if (sb.size() == TD) chk("full_mask", req, 1'b0);
        chk("ack_onehot", $countones(c_ack), ack);
        if (done) begin
            if (sb.size() == 0) begin
                chk("spurious_route", c_done, '0);
            end else begin
                e = sb.pop_front();
                chk("done_route", c_done, NCH'(1) << e.ch);
                if (e.rnw) chk("rd_data", c_rd, e.rd);
            end
        end else if (c_done != '0) begin
            chk("done_unexpected", c_done, '0);
        end
        for (int i = 0; i < NCH; i++) begin
            if (c_done[i]) cnt_done[i]++;
        end
        if (ack) dq.push_back('{cyc + lat, rdfun(addr)});
        for (int i = 0; i < NCH; i++) begin
            if (acks[i]) begin
                chk("ack_addr", addr, ca[i]);
                chk("ack_rnw", rnw, crnw[i]);
                if (!crnw[i]) chk("ack_wd", wd, cw[i]);
                sb.push_back('{i, crnw[i], rdfun(ca[i])});
                ack_log.push_back(i);
                ack_cyc.push_back(cyc);
                cnt_ack[i]++;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (acks[i]) begin
                rem[i]--;
                ca[i]++;
                cw[i]++;
            end
        end
        drive_ch();
        done = 1'b0;
        rd   = '0;
        if (dq.size() > 0 && dq[0].due <= cyc) begin
            done = 1'b1;
            rd   = dq[0].data;
            void'(dq.pop_front());
        end else if (inj) begin
            done = 1'b1;
            rd   = 8'hEE;
        end
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while ((c_req != '0 || sb.size() != 0 || dq.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk("timeout", n < budget, 1'b1);
    endtask

    initial begin
        int n;
        rst = 1'b1; ack_en = 1'b0; inj = 1'b0; done = 1'b0; rd = '0;
        c_req = '0; c_rnw = '0; c_addr = '0; c_wd = '0;
        for (int i = 0; i < NCH; i++) begin
            rem[i] = 0; ca[i] = '0; cw[i] = '0; crnw[i] = 1'b0;
        end
        clr_log();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", req, 1'b0);
        chk("rst_ack", c_ack, '0);
        chk("rst_done", c_done, '0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        ack_en = 1'b1;
        step();

        // Single channel: five writes from ch2.
        clr_log();
        lat = 2;
        set_ch(2, 5, 21'h00C000, 1'b0);
        chk("t1_idle_req", req, 1'b0);
        step();
        chk("t1_req_latency", req, 1'b1);
        run_idle(200);
        chk("t1_acks", cnt_ack[2], 5);
        chk("t1_dones", cnt_done[2], 5);
        for (int i = 0; i < NCH; i++) begin
            if (i != 2) chk("t1_other", cnt_ack[i] + cnt_done[i], 0);
        end

        // Round-robin among ch0, ch1, ch3 from a fresh reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        clr_log();
        lat = 1;
        set_ch(0, 12, 21'h010000, 1'b0);
        set_ch(1, 12, 21'h011000, 1'b1);
        set_ch(3, 12, 21'h013000, 1'b0);
        run_idle(400);
        chk("t2_count", ack_log.size(), 36);
        for (int k = 0; k < ack_log.size(); k++) begin
            chk("t2_order", ack_log[k], rr[(k / MB) % 3]);
            if (k % MB != 0) chk("t2_burst_gap", ack_cyc[k] - ack_cyc[k-1], 1);
            else if (k > 0) chk("t2_idle_gap", ack_cyc[k] - ack_cyc[k-1], 2);
        end
        chk("t2_ch2", cnt_ack[2], 0);

        // Tag routing: ch1 reads interleaved with ch0 writes, latency 3.
        clr_log();
        lat = 3;
        set_ch(1, 6, 21'h001000, 1'b1);
        set_ch(0, 6, 21'h002000, 1'b0);
        run_idle(300);
        chk("t3_ch0", cnt_done[0], 6);
        chk("t3_ch1", cnt_done[1], 6);
        chk("t3_err", err, 1'b0);

        // Backpressure: done latency 10 fills the tag FIFO.
        clr_log();
        lat = 10;
        set_ch(3, 8, 21'h003000, 1'b0);
        run_idle(400);
        chk("t4_acks", cnt_ack[3], 8);
        chk("t4_dones", cnt_done[3], 8);
        chk("t4_nacks", ack_cyc.size(), 8);
        if (ack_cyc.size() >= 5) chk("t4_resume", ack_cyc[4] - ack_cyc[0], 11);

        // Early release by ch0, then a spurious done.
        clr_log();
        lat = 2;
        set_ch(0, 2, 21'h004000, 1'b0);
        set_ch(1, 3, 21'h005000, 1'b1);
        run_idle(200);
        chk("t5_nacks", ack_log.size(), 5);
        if (ack_log.size() == 5) begin
            for (int k = 0; k < 5; k++) chk("t5_order", ack_log[k], seq5[k]);
            chk("t5_release_gap", ack_cyc[2] - ack_cyc[1], 3);
        end
        chk("t5_err_before", err, 1'b0);
        inj = 1'b1;
        step();
        inj = 1'b0;
        step();
        chk("t5_err_set", err, 1'b1);
        repeat (3) step();
        chk("t5_err_sticky", err, 1'b1);

        // Reset during a ch3 burst once the downstream side has drained.
        clr_log();
        lat = 1;
        set_ch(3, 20, 21'h006000, 1'b0);
        repeat (3) step();
        ack_en = 1'b0;
        set_ch(0, 2, 21'h007000, 1'b0);
        n = 0;
        while ((sb.size() != 0 || dq.size() != 0) && n < 50) begin
            step();
            n++;
        end
        chk("t6_drain", n < 50, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_req_after_rst", req, 1'b0);
        chk("t6_err_clr", err, 1'b0);
        chk("t6_done_clr", c_done, '0);
        clr_log();
        ack_en = 1'b1;
        run_idle(300);
        chk("t6_ch0", cnt_ack[0], 2);
        chk("t6_ch3", cnt_done[3], 18);
        if (ack_log.size() > 0) chk("t6_first_grant", ack_log[0], 0);
        chk("t6_err", err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_arbiter.md
Name: dma_arbiter

Overview:
- Shares one DMA memory port among NCH independent requesters.
- Downstream side: `req`/`rnw`/`wd`/`addr` out, with `ack`/`done`/`rd` back.
- Arbitration is round-robin with a burst lock. Each accepted access is tagged so that its in-order `done` pulse is routed back to the requester that issued it.
- Sits between the DMA clients (data suppliers/consumers, test engines) and the DMA access controller.

Parameters:
- NCH, 4, number of requester channels; 2..8 supported.
- AW, 21, address width.
- DW, 8, data width.
- MAX_BURST, 16, maximum acks per grant before forced rotation; 1..255.
- TAG_DEPTH, 4, maximum outstanding (acked but not yet done) accesses; power of 2, 2..16.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- c_req  in  NCH  per-channel access request.
- c_rnw  in  NCH  per-channel direction; 1=read.
- c_addr  in  NCH*AW  per-channel address; channel i occupies bits [i*AW +: AW].
- c_wd  in  NCH*DW  per-channel write data; same packing as c_addr.
- c_ack  out  NCH  per-channel accept strobe.
- c_done  out  NCH  per-channel completion strobe.
- c_rd  out  DW  read data; valid when any c_done bit is set.
- req  out  1  downstream request.
- rnw  out  1  downstream direction.
- addr  out  AW  downstream address.
- wd  out  DW  downstream write data.
- ack  in  1  downstream accept; only asserted while req=1.
- done  in  1  downstream completion; one pulse per acked access, in ack order, latency >=1.
- rd  in  DW  downstream read data, valid with done.
- err  out  1  sticky error flag.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, owner=0, last=NCH-1, bcnt=0.
  - Tag FIFO emptied; err=0.
  - Outputs req=0, c_ack=0, c_done=0.
  - Accesses outstanding at reset are abandoned. Their later done pulses hit an empty FIFO and set err, so the bench must hold rst until the downstream side is idle.
- State IDLE:
  - req=0.
  - If any c_req bit is set, pick the winner: the first set bit scanning last+1, last+2, ... modulo NCH.
  - Register owner=winner, bcnt=0, go to GRANT. Arbitration latency is 1 cycle after c_req rises.
- State GRANT:
  - Combinational mux: req = c_req[owner] & ~full; rnw/addr/wd = channel owner's fields.
  - addr/wd/rnw equal channel owner's values in GRANT even when req=0. In IDLE they hold the previous owner's mux values (don't-care).
  - c_ack[owner] = ack, same cycle; all other c_ack bits are 0.
  - On ack: bcnt += 1 and push owner onto the tag FIFO.
  - Exit to IDLE (last=owner) when either condition holds:
    - c_req[owner]=0 at a clock edge; or
    - an ack occurs with bcnt==MAX_BURST-1.
  - There is always one IDLE cycle between grants. A sole requester is re-granted after that gap.
- Tag FIFO:
  - Width clog2(NCH), depth TAG_DEPTH; push on ack, pop on done.
  - Simultaneous push and pop is legal; the count is unchanged.
  - full = (count==TAG_DEPTH). While full, req is masked even if a pop occurs in the same cycle. This is a 1-cycle pessimism and is intended.
- Completion routing:
  - c_done[head_tag] = done (combinational, same cycle); c_rd = rd.
  - done with an empty FIFO: err <= 1, nothing routed, FIFO unchanged.
- Requester rules: c_rnw/c_addr/c_wd must stay stable while c_req=1 and no c_ack. The requester advances its address/data on c_ack, as the existing DMA clients do.
- No combinational path from any c_req to c_ack other than through req→ack in the downstream controller.

Test Plan:
- Single channel: ch2 requests 5 writes to 0x00C000..0x00C004. Required:
  - req rises 1 cycle after c_req[2].
  - 5 c_ack[2] pulses; downstream addr matches each.
  - 5 c_done[2] pulses; no other channel sees activity.
- Round-robin: ch0, ch1 and ch3 request continuously with MAX_BURST=4. Required:
  - Grant order 0,1,3,0,1,3...
  - Exactly 4 acks per grant, 1 idle cycle between grants.
  - ch2 never acked.
- Tag routing: downstream done latency 3. Interleave ch1 reads with ch0 writes. Required:
  - Each done goes to the correct channel in order; c_rd equals the model data for each ch1 read.
- Backpressure: TAG_DEPTH=4, done delayed 10 cycles. Required:
  - After 4 acks, req=0 until the first done.
  - Then req resumes; no lost or duplicated done.
- Early release and error: ch0 drops c_req after 2 acks with MAX_BURST=16. Required:
  - Next edge goes to IDLE; ch1 granted 1 cycle later.
  - Inject a spurious done with the FIFO empty: err=1 and stays 1 until rst.
- Reset mid-burst: assert rst for 1 cycle during a ch3 burst. Required:
  - Next cycle req=0 and FIFO empty.
  - Grant restarts scanning from ch0.
